// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Brief    : Arbitrates the 6-digit seven-segment display among NREQ sources,
//            scans the digits and decodes 6-bit character codes. Optional
//            macro DISPLAY_ARBITER_BLINK_EN blinks urgent content.
// Revision : 1.0
// ============================================================================
module display_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWELL_CYC = 100000000,
    parameter int SCAN_DIV  = 13,
    parameter int BLINK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      urgent,
    input  logic                 lock,
    input  logic [36*NREQ-1:0]   nums,
    output logic [NREQ-1:0]      grant,
    output logic                 grant_valid,
    output logic                 urgent_active,
    output logic [5:0]           digit,
    output logic [6:0]           display
);
    localparam int c_PTR_W = $clog2(NREQ);
    localparam int c_DW    = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, URGENT = 2'd2} state_t;

    state_t               r_state, w_state_nxt;
    logic [NREQ-1:0]      r_grant, w_grant_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_DW-1:0]      r_dwell, w_dwell_nxt;
    logic [c_PTR_W:0]     w_pick_all, w_pick_oth;
    logic [SCAN_DIV-1:0]  r_prescale;
    logic [2:0]           r_idx;
    logic [5:0]           r_digit;
    logic [6:0]           r_display;
    logic [35:0]          w_src;
    logic [5:0]           w_char;
    logic                 w_blank;

    function automatic logic [NREQ-1:0] f_lowest(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] res;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // {found, index} of the first set bit after ptr, looking at most span places ahead
    function automatic logic [c_PTR_W:0] f_rr_pick(input logic [NREQ-1:0] v,
                                                   input logic [c_PTR_W-1:0] ptr,
                                                   input int span);
        logic [c_PTR_W:0]   res;
        logic [c_PTR_W-1:0] j;
        res = '0;
        for (int off = span; off >= 1; off--) begin
            j = c_PTR_W'((int'(ptr) + off) % NREQ);
            if (v[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    function automatic logic [6:0] f_decode(input logic [5:0] c);
        case (c)
            6'd0:  f_decode = 7'b1000000;  6'd1:  f_decode = 7'b1111001;
            6'd2:  f_decode = 7'b0100100;  6'd3:  f_decode = 7'b0110000;
            6'd4:  f_decode = 7'b0011001;  6'd5:  f_decode = 7'b0010010;
            6'd6:  f_decode = 7'b0000010;  6'd7:  f_decode = 7'b1111000;
            6'd8:  f_decode = 7'b0000000;  6'd9:  f_decode = 7'b0010000;
            6'd10: f_decode = ~7'h77;      6'd11: f_decode = ~7'h7C;
            6'd12: f_decode = ~7'h39;      6'd13: f_decode = ~7'h5E;
            6'd14: f_decode = ~7'h79;      6'd15: f_decode = ~7'h71;
            6'd16: f_decode = ~7'h3D;      6'd17: f_decode = ~7'h74;
            6'd18: f_decode = ~7'h30;      6'd19: f_decode = ~7'h1E;
            6'd20: f_decode = ~7'h75;      6'd21: f_decode = ~7'h38;
            6'd22: f_decode = ~7'h37;      6'd23: f_decode = ~7'h54;
            6'd24: f_decode = ~7'h5C;      6'd25: f_decode = ~7'h73;
            6'd26: f_decode = ~7'h67;      6'd27: f_decode = ~7'h50;
            6'd28: f_decode = ~7'h6D;      6'd29: f_decode = ~7'h78;
            6'd30: f_decode = ~7'h3E;      6'd31: f_decode = ~7'h1C;
            6'd32: f_decode = ~7'h2A;      6'd33: f_decode = ~7'h76;
            6'd34: f_decode = ~7'h6E;      6'd35: f_decode = ~7'h5B;
            6'd63: f_decode = 7'b0111111;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= c_PTR_W'(NREQ - 1);
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_dwell  <= w_dwell_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_dwell_nxt  = '0;
        w_pick_all   = f_rr_pick(req, r_rr_ptr, NREQ);
        w_pick_oth   = f_rr_pick(req, r_rr_ptr, NREQ - 1);
        unique case (r_state)
            IDLE: begin
                if (|urgent) begin
                    w_state_nxt = URGENT;
                    w_grant_nxt = f_lowest(urgent);
                end else if (w_pick_all[c_PTR_W]) begin
                    w_state_nxt  = SHOW;
                    w_grant_nxt  = '0;
                    w_grant_nxt[w_pick_all[c_PTR_W-1:0]] = 1'b1;
                    w_rr_ptr_nxt = w_pick_all[c_PTR_W-1:0];
                end
            end
            SHOW: begin
                if (|urgent) begin
                    w_state_nxt = URGENT;
                    w_grant_nxt = f_lowest(urgent);
                end else if ((req & r_grant) == '0) begin
                    if (w_pick_all[c_PTR_W]) begin
                        w_grant_nxt  = '0;
                        w_grant_nxt[w_pick_all[c_PTR_W-1:0]] = 1'b1;
                        w_rr_ptr_nxt = w_pick_all[c_PTR_W-1:0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (r_dwell == c_DWELL_LAST) begin
                    if (!lock && w_pick_oth[c_PTR_W]) begin
                        w_grant_nxt  = '0;
                        w_grant_nxt[w_pick_oth[c_PTR_W-1:0]] = 1'b1;
                        w_rr_ptr_nxt = w_pick_oth[c_PTR_W-1:0];
                    end
                end else if (!lock) begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            URGENT: begin
                // No urgent-to-urgent preemption: only a drop of the holder releases it
                if ((urgent & r_grant) == '0) begin
                    if (|urgent) begin
                        w_grant_nxt = f_lowest(urgent);
                    end else if (w_pick_all[c_PTR_W]) begin
                        w_state_nxt  = SHOW;
                        w_grant_nxt  = '0;
                        w_grant_nxt[w_pick_all[c_PTR_W-1:0]] = 1'b1;
                        w_rr_ptr_nxt = w_pick_all[c_PTR_W-1:0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef DISPLAY_ARBITER_BLINK_EN
    logic [BLINK_DIV:0] r_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
        end else if (w_state_nxt == URGENT && (r_state != URGENT || w_grant_nxt != r_grant)) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    assign w_blank = (r_state == URGENT) && r_blink[BLINK_DIV];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_src = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) w_src = w_src | nums[i*36 +: 36];
        end
        case (r_idx)
            3'd0:    w_char = w_src[5:0];
            3'd1:    w_char = w_src[11:6];
            3'd2:    w_char = w_src[17:12];
            3'd3:    w_char = w_src[23:18];
            3'd4:    w_char = w_src[29:24];
            default: w_char = w_src[35:30];
        endcase
    end

    // Prescaler is free-running across grant changes so the scan never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_idx      <= '0;
            r_digit    <= 6'b111111;
            r_display  <= 7'b1111111;
        end else begin
            r_prescale <= r_prescale + 1'b1;
            if (&r_prescale) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            r_digit <= ~(6'b000001 << r_idx);
            if (r_state == IDLE || w_blank) r_display <= 7'b1111111;
            else                            r_display <= f_decode(w_char);
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = |r_grant;
    assign urgent_active = (r_state == URGENT);
    assign digit         = r_digit;
    assign display       = r_display;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Brief    : Self-checking bench for display_arbiter with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_display_arbiter;
    localparam int NREQ      = 4;
    localparam int DWELL     = 16;
    localparam int SCAN_DIV  = 2;
    localparam int BLINK_DIV = 3;
`ifdef DISPLAY_ARBITER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    urgent = '0;
    logic               lock = 1'b0;
    logic [36*NREQ-1:0] nums = '0;
    logic [NREQ-1:0]    grant;
    logic               grant_valid;
    logic               urgent_active;
    logic [5:0]         digit;
    logic [6:0]         display;

    int ntests = 0;
    int nfail  = 0;

    display_arbiter #(
        .NREQ(NREQ), .DWELL_CYC(DWELL), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .urgent(urgent), .lock(lock), .nums(nums),
        .grant(grant), .grant_valid(grant_valid), .urgent_active(urgent_active),
        .digit(digit), .display(display)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] DIG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [6:0] LET [0:25] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h74, 7'h30,
                               7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50,
                               7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h76, 7'h6E, 7'h5B};

    int m_mode = 0;   // 0 idle, 1 show, 2 urgent
    int m_g = -1, m_ptr = NREQ - 1, m_dwell = 0, m_pre = 0, m_idx = 0, m_blink = 0;
    logic [NREQ-1:0] e_grant = '0;
    logic [5:0]      e_digit = 6'b111111;
    logic [6:0]      e_disp  = 7'b1111111;

    function automatic logic [6:0] glyph(input int c);
        if (c < 10)       return DIG[c];
        else if (c < 36)  return ~LET[c-10];
        else if (c == 63) return 7'b0111111;
        else              return 7'b1111111;
    endfunction

    function automatic int lowest(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_from(input logic [NREQ-1:0] v, input int p, input int span);
        for (int off = 1; off <= span; off++) if (v[(p + off) % NREQ]) return (p + off) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_g = -1; m_ptr = NREQ - 1; m_dwell = 0;
            m_pre = 0; m_idx = 0; m_blink = 0;
            e_grant = '0; e_digit = 6'b111111; e_disp = 7'b1111111;
        end else begin
            int nu, n, old_mode, old_g;
            e_digit = ~(6'b000001 << m_idx);
            if (m_mode == 0 || (BLINK && m_mode == 2 && ((m_blink >> BLINK_DIV) & 1) == 1))
                e_disp = 7'b1111111;
            else
                e_disp = glyph(int'(nums[36*m_g + 6*m_idx +: 6]));
            m_pre = m_pre + 1;
            if (m_pre == (1 << SCAN_DIV)) begin m_pre = 0; m_idx = (m_idx + 1) % 6; end
            old_mode = m_mode; old_g = m_g;
            nu = lowest(urgent);
            if (m_mode == 0) begin
                if (nu >= 0) begin m_mode = 2; m_g = nu; end
                else begin
                    n = rr_from(req, m_ptr, NREQ);
                    if (n >= 0) begin m_mode = 1; m_g = n; m_ptr = n; m_dwell = 0; end
                end
            end else if (m_mode == 1) begin
                if (nu >= 0) begin m_mode = 2; m_g = nu; m_dwell = 0; end
                else if (!req[m_g]) begin
                    n = rr_from(req, m_ptr, NREQ);
                    m_dwell = 0;
                    if (n >= 0) begin m_g = n; m_ptr = n; end
                    else begin m_mode = 0; m_g = -1; end
                end else if (m_dwell == DWELL - 1) begin
                    m_dwell = 0;
                    n = rr_from(req, m_ptr, NREQ - 1);
                    if (!lock && n >= 0) begin m_g = n; m_ptr = n; end
                end else if (lock) m_dwell = 0;
                else m_dwell = m_dwell + 1;
            end else begin
                if (!urgent[m_g]) begin
                    if (nu >= 0) m_g = nu;
                    else begin
                        n = rr_from(req, m_ptr, NREQ);
                        if (n >= 0) begin m_mode = 1; m_g = n; m_ptr = n; m_dwell = 0; end
                        else begin m_mode = 0; m_g = -1; end
                    end
                end
            end
            if (m_mode == 2 && (old_mode != 2 || old_g != m_g)) m_blink = 0;
            else m_blink = (m_blink + 1) % (2 << BLINK_DIV);
            e_grant = (m_g < 0) ? '0 : NREQ'(1 << m_g);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare all outputs against the model
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            ntests++;
            if (grant !== e_grant || grant_valid !== (e_grant != '0) ||
                urgent_active !== (m_mode == 2) || digit !== e_digit || display !== e_disp) begin
                nfail++;
                $display("FAIL model t=%0t: grant %b/%b gv %b ua %b/%0d digit %b/%b display %b/%b",
                         $time, grant, e_grant, grant_valid, urgent_active, m_mode,
                         digit, e_digit, display, e_disp);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_grant"},   32'(grant), 32'd0);
        chk({name, "_gv"},      32'(grant_valid), 32'd0);
        chk({name, "_ua"},      32'(urgent_active), 32'd0);
        chk({name, "_digit"},   32'(digit), 32'h3f);
        chk({name, "_display"}, 32'(display), 32'h7f);
    endtask

    task automatic wait_digit(input string name, input logic [5:0] d);
        int k;
        k = 0;
        while (digit == d && k < 40) begin tick(); k++; end
        while (digit != d && k < 40) begin tick(); k++; end
        chk({name, "_timeout"}, 32'(k < 40), 32'd1);
    endtask

    task automatic rand_nums();
        for (int s = 0; s < NREQ; s++)
            for (int k = 0; k < 6; k++) nums[36*s + 6*k +: 6] = 6'($urandom_range(0, 63));
    endtask

    initial begin
        rand_nums();
        ticks(3);
        chk_reset("reset");
        rst = 1'b0;

        // Round-robin with dwell
        req = 4'b0101;
        tick();
        chk("first_grant", 32'(grant), 32'b0001);
        ticks(15);
        chk("dwell_hold", 32'(grant), 32'b0001);
        tick();
        chk("dwell_rotate", 32'(grant), 32'b0100);
        ticks(16);
        chk("dwell_wrap", 32'(grant), 32'b0001);

        // Urgent preemption and return to round-robin
        urgent = 4'b1000; req = 4'b1101;
        tick();
        chk("urg_grant", 32'(grant), 32'b1000);
        chk("urg_active", 32'(urgent_active), 32'd1);
        urgent = 4'b0000; req = 4'b0101;
        tick();
        chk("urg_return", 32'(grant), 32'b0100);

        // Urgent from idle, then hand-over on drop
        req = 4'b0000;
        tick();
        chk("to_idle", 32'(grant_valid), 32'd0);
        urgent = 4'b0110; req = 4'b0110;
        tick();
        chk("urg_lowest", 32'(grant), 32'b0010);
        urgent = 4'b0100; req = 4'b0100;
        tick();
        chk("urg_handover", 32'(grant), 32'b0100);
        chk("urg_still", 32'(urgent_active), 32'd1);

        // Lock freezes rotation but not a request drop
        urgent = 4'b0000; req = 4'b0011; lock = 1'b1;
        tick();
        chk("lock_grant", 32'(grant), 32'b0001);
        ticks(40);
        chk("lock_hold", 32'(grant), 32'b0001);
        req = 4'b0010;
        tick();
        chk("lock_drop", 32'(grant), 32'b0010);

        // Scan and decode of source 0
        for (int k = 0; k < 6; k++) nums[6*k +: 6] = 6'(k);
        req = 4'b0001;
        tick();
        chk("scan_grant", 32'(grant), 32'b0001);
        wait_digit("scan0", 6'b111110);
        chk("scan0_disp", 32'(display), 32'b1000000);
        ticks(4);
        chk("scan1_digit", 32'(digit), 32'b111101);
        chk("scan1_disp", 32'(display), 32'b1111001);
        ticks(4);
        chk("scan2_digit", 32'(digit), 32'b111011);
        chk("scan2_disp", 32'(display), 32'b0100100);
        nums[5:0] = 6'd63;
        wait_digit("dash", 6'b111110);
        chk("dash_disp", 32'(display), 32'b0111111);

        // Urgent display: blinks only when the feature is built in
        urgent = 4'b0001; req = 4'b0001;
        ticks(9);
        chk("blink_first_half", 32'(display != 7'h7f), 32'd1);
        tick();
        chk("blink_second_half", 32'(display == 7'h7f), 32'(BLINK));
        ticks(20);
        urgent = 4'b0000; lock = 1'b0;

        // Randomized traffic with occasional asynchronous reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0)  req = NREQ'($urandom);
            if ($urandom_range(0, 15) == 0) urgent = NREQ'($urandom & $urandom & $urandom);
            req = req | urgent;
            if ($urandom_range(0, 29) == 0) lock = ~lock;
            if ($urandom_range(0, 99) == 0) rand_nums();
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                #1 chk_reset("midreset");
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 6-digit seven-segment display between up to NREQ content sources (clock, timer, alarm, stopwatch, keyboard entry).
- Arbitration rules:
  - Urgent requesters (alarm/timer match) preempt normal ones, lowest index first.
  - Normal requesters rotate round-robin with a fixed dwell time.
- Also scans the digits and decodes the granted source's 6-bit character codes to segment patterns.
- Replaces the ad-hoc priority mux and scan logic at top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL_CYC, 100000000, clk cycles a normal grant is held before rotating when others are waiting.
- SCAN_DIV, 13, digit advances once every 2^SCAN_DIV clk cycles.
- BLINK_DIV, 25, blink half-period is 2^BLINK_DIV cycles; used only with BLINK_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  normal display request per source
- urgent  in  NREQ  urgent request per source; implies req
- lock  in  1  freeze the current normal grant (keyboard editing); ignored for urgent
- nums  in  36*NREQ  source i occupies bits [36i+35:36i]; 6 chars x 6 bits, char 0 in the LSBs = rightmost digit
- grant  out  NREQ  one-hot registered grant, all-zero when idle
- grant_valid  out  1  high when grant is nonzero
- urgent_active  out  1  high in state URGENT
- digit  out  6  active-low digit enable, one bit low at a time
- display  out  7  active-low segments gfedcba

Behaviour:
- Reset values (async):
  - state IDLE, grant 0, grant_valid 0, urgent_active 0.
  - rr_ptr = NREQ-1, so the first normal grant goes to index 0.
  - dwell counter 0, scan prescaler 0, scan index 0.
  - digit 6'b111111, display 7'b1111111.
- Grant latency: a new grant is visible on the cycle after the causing inputs are sampled.
- FSM states IDLE, SHOW, URGENT:
  - IDLE:
    - any urgent → URGENT, grant the lowest set urgent bit;
    - else any req → SHOW, grant the first set req after rr_ptr (wrapping), rr_ptr := that index, dwell := 0;
    - else stay IDLE.
  - SHOW:
    - Any urgent → URGENT; rr_ptr unchanged.
    - Else req[g] drops → the next req after rr_ptr goes to SHOW; none → IDLE. This happens even when lock is high.
    - Else dwell == DWELL_CYC-1:
      - if !lock and another req is pending, rotate to it and clear dwell;
      - otherwise clear dwell and keep the grant.
    - Dwell counts only in SHOW. lock high holds dwell at 0.
  - URGENT:
    - Hold while urgent[g] is high, even if another source asserts urgent. There is no urgent-to-urgent preemption.
    - On urgent[g] drop: any other urgent → grant the lowest one; else any req → SHOW via round-robin from rr_ptr; else IDLE.
- Simultaneous events:
  - urgent wins over dwell expiry and over req drop in the same cycle.
  - Several urgents in IDLE or SHOW: lowest index wins.
- Scan:
  - The prescaler is free-running and is not reset on grant change.
  - On prescaler wrap, the index advances 0→5→0.
  - digit[idx] = 0, others 1. Registered: one cycle after the index update.
- Display:
  - display is registered from the char of the current grant at index idx.
  - IDLE shows blank (7'b1111111) with digits still scanning.
- Character decode (active-low gfedcba):
  - 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - 10..35: letters a..z, using the bitwise complement of the team's alphabet glyph table.
  - 36..62: blank.
  - 63: dash, 0111111.
- Width rules:
  - The dwell counter is sized clog2(DWELL_CYC); it must not overflow.
  - rr_ptr is sized clog2(NREQ).
- Reset mid-operation: everything returns to reset values asynchronously. No grant persists.

Optional Feature:
- Macro DISPLAY_ARBITER_BLINK_EN.
- Defined:
  - in URGENT, a free-running 2^BLINK_DIV-cycle counter gates display;
  - during the second half-period display = 7'b1111111, and digit keeps scanning.
  - The counter is cleared on entry to URGENT, so the first half-period is visible.
- Undefined: the urgent source is shown steadily, and the blink counter is not instantiated.

Test Plan (NREQ=4, DWELL_CYC=16, SCAN_DIV=2, BLINK_DIV=3):
- Reset, then req=4'b0101 → grant 0001 one cycle later; after 16 cycles grant 0100; after 16 more grant 0001.
- SHOW grant 0001, urgent=4'b1000 → next cycle grant 1000, urgent_active=1; urgent drops with req=0101 → grant 0100 (round-robin continues after 0).
- urgent=4'b0110 in IDLE → grant 0010; urgent[1] drops → grant 0100, still URGENT.
- lock=1 with grant 0001 and req=0011 for 40 cycles → grant stays 0001; req[0] drops → grant 0010 next cycle.
- Source 0 nums = chars {5,4,3,2,1,0} (char 0 = 0), granted → digit sequence 111110,111101,… every 4 cycles with display 1000000,1111001,0100100,…; char 63 → 0111111.
- With BLINK_EN: urgent grant → display alternates 8 cycles glyph / 8 cycles 1111111 while digit keeps cycling. Without BLINK_EN: steady glyph.
